tx_burst_ctrl: RTL



---
 rtl/tx_burst_ctrl_if.sv | 32 +++
 rtl/tx_burst_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/tx_burst_ctrl_if.sv
// Handshake and status bundle between the start/abort source and the
// transmit burst sequencer.
interface tx_burst_ctrl_if #(
   parameter int CNT_W = 16,
   parameter int GAP_W = 16
);

   logic             start;
   logic             abort;
   logic [CNT_W-1:0] burst_len;
   logic [GAP_W-1:0] gap_len;
   logic [3:0]       speed_sel;

   logic             send_enable;
   logic             frame_active;
   logic [3:0]       speed_ctr;
   logic             busy;
   logic             done;
   logic             aborted;
   logic [CNT_W-1:0] frames_sent;

   modport master (
      output start, abort, burst_len, gap_len, speed_sel,
      input  send_enable, frame_active, speed_ctr, busy, done, aborted, frames_sent
   );

   modport slave (
      input  start, abort, burst_len, gap_len, speed_sel,
      output send_enable, frame_active, speed_ctr, busy, done, aborted, frames_sent
   );

endinterface

// File: rtl/tx_burst_ctrl.sv
// Transmit burst sequencer: issues burst_len frame-start pulses to the PRBS
// frame generator, separated by gap_len idle cycles, with abort support.
module tx_burst_ctrl #(
   parameter int FRAME_WORDS = 20,
   parameter int CNT_W       = 16,
   parameter int GAP_W       = 16
) (
   input  logic           clk,
   input  logic           rst,
   tx_burst_ctrl_if.slave bus
);

   localparam int WORD_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(FRAME_WORDS - 1);

   typedef enum logic [2:0] {IDLE, SEND, FRAME, GAP, DONE} state_t;

   state_t            state, state_next;
   logic [WORD_W-1:0] word_cnt, word_cnt_next;
   logic [GAP_W-1:0]  gap_cnt, gap_cnt_next;
   logic [GAP_W-1:0]  gap_q, gap_q_next;
   logic [CNT_W-1:0]  len_q, len_q_next;
   logic [CNT_W-1:0]  frames_next;
   logic [3:0]        speed_next;
   logic              aborted_next;

   // Abort overrides every busy-state exit; a partial frame is never counted.
   always_comb begin
      state_next    = state;
      word_cnt_next = word_cnt;
      gap_cnt_next  = gap_cnt;
      gap_q_next    = gap_q;
      len_q_next    = len_q;
      frames_next   = bus.frames_sent;
      speed_next    = bus.speed_ctr;
      aborted_next  = 1'b0;

      if (state != IDLE && bus.abort) begin
         state_next   = IDLE;
         aborted_next = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  len_q_next    = bus.burst_len;
                  gap_q_next    = bus.gap_len;
                  speed_next    = bus.speed_sel;
                  frames_next   = '0;
                  word_cnt_next = '0;
                  gap_cnt_next  = '0;
                  state_next    = (bus.burst_len == '0) ? DONE : SEND;
               end
            end
            SEND: begin
               word_cnt_next = '0;
               state_next    = FRAME;
            end
            FRAME: begin
               if (word_cnt == LAST_WORD) begin
                  frames_next = bus.frames_sent + 1'b1;
                  if (frames_next == len_q) begin
                     state_next = DONE;
                  end else if (gap_q == '0) begin
                     state_next = SEND;
                  end else begin
                     gap_cnt_next = '0;
                     state_next   = GAP;
                  end
               end else begin
                  word_cnt_next = word_cnt + 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt == gap_q - 1'b1) begin
                  state_next = SEND;
               end else begin
                  gap_cnt_next = gap_cnt + 1'b1;
               end
            end
            DONE: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         word_cnt         <= '0;
         gap_cnt          <= '0;
         gap_q            <= '0;
         len_q            <= '0;
         bus.send_enable  <= 1'b0;
         bus.frame_active <= 1'b0;
         bus.speed_ctr    <= '0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.aborted      <= 1'b0;
         bus.frames_sent  <= '0;
      end else begin
         state            <= state_next;
         word_cnt         <= word_cnt_next;
         gap_cnt          <= gap_cnt_next;
         gap_q            <= gap_q_next;
         len_q            <= len_q_next;
         bus.send_enable  <= (state_next == SEND);
         bus.frame_active <= (state_next == FRAME);
         bus.speed_ctr    <= speed_next;
         bus.busy         <= (state_next != IDLE);
         bus.done         <= (state_next == DONE);
         bus.aborted      <= aborted_next;
         bus.frames_sent  <= frames_next;
      end
   end

endmodule
